// File: rtl/motoro3_pkg.sv
// Purpose: shared step-band, request and phase-FSM definitions for the motoro3 gate driver.
// Latency: none, declarations and one combinational helper only.
// Backpressure: none.
package motoro3_pkg;

   // Step code the step generator emits when a phase is parked.
   localparam logic [3:0] STEP_IDLE = 4'hE;

   typedef enum logic [1:0] {
      BAND_HIGH  = 2'd0,
      BAND_LOW   = 2'd1,
      BAND_FLOAT = 2'd2,
      BAND_NONE  = 2'd3
   } band_t;

   typedef enum logic [1:0] {
      PH_OFF  = 2'd0,
      PH_DEAD = 2'd1,
      PH_HI   = 2'd2,
      PH_LO   = 2'd3
   } ph_state_t;

   typedef enum logic [1:0] {
      REQ_OFF = 2'd0,
      REQ_H   = 2'd1,
      REQ_L   = 2'd2
   } req_t;

   // Steps 0..3 drive the high band, 4..7 the low band, 8..11 float;
   // anything else (idle code included) or an inactive interface is no band.
   function automatic band_t step_band(input logic [3:0] step, input logic active);
      band_t b;
      b = BAND_NONE;
      if (active && step != STEP_IDLE) begin
         if (step < 4'd4)       b = BAND_HIGH;
         else if (step < 4'd8)  b = BAND_LOW;
         else if (step < 4'd12) b = BAND_FLOAT;
      end
      return b;
   endfunction

endpackage

// File: rtl/motoro3_phase_gate.sv
// Purpose: one inverter leg: band decode, OFF/DEAD/HI/LO FSM and dead-time counter.
// Latency: request to gate-on DEAD_CYC+1 falling edges; request OFF or stop drops gates on the next edge.
// Backpressure: none; requests are levels re-evaluated every cycle.
module motoro3_phase_gate
   import motoro3_pkg::*;
#(
   parameter int DEAD_CYC = 10
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [3:0] step,
   input  logic       active,
   input  logic       stop,
   input  logic       pwm_on,
   output logic       gate_h,
   output logic       gate_l
);

   localparam int              DC_W        = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam logic [DC_W-1:0] DEAD_RELOAD = DC_W'(DEAD_CYC - 1);

   ph_state_t       state, state_nxt;
   logic [DC_W-1:0] dcnt, dcnt_nxt;
   req_t            req;

   // Translate the step band into a gate request; high band is complementary PWM.
   always_comb begin
      req = REQ_OFF;
      case (step_band(step, active))
         BAND_HIGH: req = pwm_on ? REQ_H : REQ_L;
         BAND_LOW:  req = REQ_L;
         default:   req = REQ_OFF;
      endcase
   end

   // Next state: any turn-on passes through DEAD; DEAD runs to completion once started.
   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      if (stop) begin
         state_nxt = PH_OFF;
      end else begin
         case (state)
            PH_OFF: begin
               if (req != REQ_OFF) begin
                  state_nxt = PH_DEAD;
                  dcnt_nxt  = DEAD_RELOAD;
               end
            end
            PH_HI: begin
               if (req == REQ_L) begin
                  state_nxt = PH_DEAD;
                  dcnt_nxt  = DEAD_RELOAD;
               end else if (req == REQ_OFF) begin
                  state_nxt = PH_OFF;
               end
            end
            PH_LO: begin
               if (req == REQ_H) begin
                  state_nxt = PH_DEAD;
                  dcnt_nxt  = DEAD_RELOAD;
               end else if (req == REQ_OFF) begin
                  state_nxt = PH_OFF;
               end
            end
            default: begin
               if (dcnt == '0) begin
                  case (req)
                     REQ_H:   state_nxt = PH_HI;
                     REQ_L:   state_nxt = PH_LO;
                     default: state_nxt = PH_OFF;
                  endcase
               end else begin
                  dcnt_nxt = dcnt - DC_W'(1);
               end
            end
         endcase
      end
   end

   // State, counter and gates register together so gates always equal the current state.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         state  <= PH_OFF;
         dcnt   <= '0;
         gate_h <= 1'b0;
         gate_l <= 1'b0;
      end else begin
         state  <= state_nxt;
         dcnt   <= dcnt_nxt;
         gate_h <= (state_nxt == PH_HI);
         gate_l <= (state_nxt == PH_LO);
      end
   end

endmodule

// File: rtl/motoro3_gate_driver.sv
// Purpose: 3-phase gate driver: shared PWM carrier and duty latch feeding three phase legs.
// Latency: step/duty to gate-on DEAD_CYC+1 falling edges; stop and request-OFF act on the next edge.
// Backpressure: none; duty is only taken at carrier wrap, steps are levels.
module motoro3_gate_driver
   import motoro3_pkg::*;
#(
   parameter int PWM_PERIOD = 500,
   parameter int DEAD_CYC   = 10,
   parameter int DUTY_W     = 9
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic [3:0]        m3stepA,
   input  logic [3:0]        m3stepB,
   input  logic [3:0]        m3stepC,
   input  logic              pwmActive1,
   input  logic              m3stop,
   input  logic [DUTY_W-1:0] duty,
   output logic              gAH,
   output logic              gAL,
   output logic              gBH,
   output logic              gBL,
   output logic              gCH,
   output logic              gCL,
   output logic              carrierWrap
);

   // Wide enough to hold PWM_PERIOD itself, which is the 100 % duty value.
   localparam int CNT_W = $clog2(PWM_PERIOD + 1);

   if (DEAD_CYC < 1) begin : g_bad_dead
      $error("motoro3_gate_driver: DEAD_CYC must be at least 1");
   end
   if ((2 ** DUTY_W) < PWM_PERIOD) begin : g_bad_duty_w
      $error("motoro3_gate_driver: DUTY_W too narrow for PWM_PERIOD");
   end

   logic [CNT_W-1:0] carrier, duty_q, duty_clamped;
   logic             at_end, pwm_on;

   assign at_end = (carrier == CNT_W'(PWM_PERIOD - 1));
   assign pwm_on = (carrier < duty_q);

   // Saturate oversized duty requests to a full period.
   always_comb begin
      duty_clamped = CNT_W'(duty);
      if (32'(duty) >= PWM_PERIOD) duty_clamped = CNT_W'(PWM_PERIOD);
   end

   // Free-running carrier; duty latches on the last count so it applies from carrier 0.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         carrier     <= '0;
         duty_q      <= '0;
         carrierWrap <= 1'b0;
      end else begin
         carrier     <= at_end ? '0 : carrier + CNT_W'(1);
         carrierWrap <= at_end;
         if (at_end) duty_q <= duty_clamped;
      end
   end

   motoro3_phase_gate #(.DEAD_CYC(DEAD_CYC)) u_phase_a (
      .clk(clk), .nRst(nRst), .step(m3stepA), .active(pwmActive1), .stop(m3stop),
      .pwm_on(pwm_on), .gate_h(gAH), .gate_l(gAL)
   );

   motoro3_phase_gate #(.DEAD_CYC(DEAD_CYC)) u_phase_b (
      .clk(clk), .nRst(nRst), .step(m3stepB), .active(pwmActive1), .stop(m3stop),
      .pwm_on(pwm_on), .gate_h(gBH), .gate_l(gBL)
   );

   motoro3_phase_gate #(.DEAD_CYC(DEAD_CYC)) u_phase_c (
      .clk(clk), .nRst(nRst), .step(m3stepC), .active(pwmActive1), .stop(m3stop),
      .pwm_on(pwm_on), .gate_h(gCH), .gate_l(gCL)
   );

endmodule

// File: tb/tb_motoro3_gate_driver.sv
// Purpose: self-checking bench for motoro3_gate_driver against a cycle-count reference model.
// Latency: outputs sampled on the rising edge, half a cycle after the falling-edge update.
// Backpressure: none.
`timescale 1ns/1ps
module tb_motoro3_gate_driver;

   localparam int PERIOD = 500;
   localparam int DEAD   = 10;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic [3:0] m3stepA = 4'd0, m3stepB = 4'd8, m3stepC = 4'd4;
   logic       pwmActive1 = 1'b1;
   logic       m3stop = 1'b0;
   logic [8:0] duty = 9'd250;
   logic       gAH, gAL, gBH, gBL, gCH, gCL, carrierWrap;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: edges since reset, latched duty, per-phase output
   // (0 off, 1 high, 2 low) and the absolute edge at which a pending turn-on resolves.
   int kcyc, mdq;
   bit mwrap;
   int mo [3];
   int mon [3];

   always #50 clk = ~clk;

   motoro3_gate_driver dut (
      .clk(clk), .nRst(nRst), .m3stepA(m3stepA), .m3stepB(m3stepB), .m3stepC(m3stepC),
      .pwmActive1(pwmActive1), .m3stop(m3stop), .duty(duty),
      .gAH(gAH), .gAL(gAL), .gBH(gBH), .gBL(gBL), .gCH(gCH), .gCL(gCL),
      .carrierWrap(carrierWrap)
   );

   function automatic logic [6:0] dut_vec();
      return {gAH, gAL, gBH, gBL, gCH, gCL, carrierWrap};
   endfunction

   function automatic logic [6:0] exp_vec();
      return {mo[0] == 1, mo[0] == 2, mo[1] == 1, mo[1] == 2, mo[2] == 1, mo[2] == 2, mwrap};
   endfunction

   function automatic int req_of(input logic [3:0] s, input int c);
      if (!pwmActive1 || s > 4'd11) return 0;
      if (s < 4'd4) return (c < mdq) ? 1 : 2;
      if (s < 4'd8) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      kcyc = 0; mdq = 0; mwrap = 1'b0;
      for (int p = 0; p < 3; p++) begin mo[p] = 0; mon[p] = -1; end
   endtask

   task automatic model_edge();
      int c, r;
      logic [3:0] st [3];
      st[0] = m3stepA; st[1] = m3stepB; st[2] = m3stepC;
      c = kcyc % PERIOD;
      for (int p = 0; p < 3; p++) begin
         r = req_of(st[p], c);
         if (m3stop) begin
            mo[p] = 0; mon[p] = -1;
         end else if (mon[p] >= 0) begin
            if (kcyc == mon[p]) begin mo[p] = r; mon[p] = -1; end
         end else if (r == 0) begin
            mo[p] = 0;
         end else if (r != mo[p]) begin
            mo[p] = 0; mon[p] = kcyc + DEAD;
         end
      end
      if (c == PERIOD - 1) mdq = (duty >= PERIOD) ? PERIOD : int'(duty);
      kcyc++;
      mwrap = ((kcyc % PERIOD) == 0);
   endtask

   task automatic tick();
      if (nRst) model_edge();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic wait_wrap(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < PERIOD + 5; i++) begin
         if (carrierWrap) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   // Observes one carrier period starting right after a wrap sample.
   task automatic measure_period(input int chg_at, input logic [8:0] new_duty,
                                 output int ah_n, output int al_n, output int ovl,
                                 output int gaps, output int bad_gaps, output int mism);
      int run;
      ah_n = 0; al_n = 0; ovl = 0; gaps = 0; bad_gaps = 0; mism = 0; run = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i == chg_at) duty = new_duty;
         tick();
         if (dut_vec() !== exp_vec()) mism++;
         ah_n += int'(gAH);
         al_n += int'(gAL);
         ovl  += int'(gAH & gAL);
         if (!gAH && !gAL) run++;
         else begin
            if (run > 0) begin gaps++; if (run != DEAD) bad_gaps++; end
            run = 0;
         end
      end
   endtask

   task automatic test_reset();
      int first_cl;
      bit b_on, c_h;
      model_reset();
      nRst = 1'b0; m3stepA = 4'd0; m3stepB = 4'd8; m3stepC = 4'd4; duty = 9'd250;
      repeat (3) @(posedge clk);
      if (dut_vec() !== 7'b0) begin
         n_fail++; $display("FAIL reset_state got=%b want=%b", dut_vec(), 7'b0);
      end
      n_cmp++;
      nRst = 1'b1;
      first_cl = -1; b_on = 1'b0; c_h = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
         end
         n_cmp++;
         if (gCL && first_cl < 0) first_cl = i;
         if (gBH || gBL) b_on = 1'b1;
         if (gCH) c_h = 1'b1;
      end
      if (first_cl != DEAD + 1) begin
         n_fail++; $display("FAIL cl_latency got=%0d want=%0d", first_cl, DEAD + 1);
      end
      n_cmp++;
      if (b_on || c_h) begin
         n_fail++; $display("FAIL float_low_gates b_on=%0b c_h=%0b want 0 0", b_on, c_h);
      end
      n_cmp++;
   endtask

   task automatic test_dead_time();
      bit ok;
      int ah, al, ovl, gaps, bad, mism;
      wait_wrap(ok);
      if (!ok) begin n_fail++; $display("FAIL dead_wrap_timeout got=0 want=1"); end
      n_cmp++;
      measure_period(-1, duty, ah, al, ovl, gaps, bad, mism);
      if (ah != 240 || al != 240) begin
         n_fail++; $display("FAIL dead_windows ah=%0d al=%0d want 240 240", ah, al);
      end
      n_cmp++;
      if (ovl != 0 || gaps != 2 || bad != 0) begin
         n_fail++; $display("FAIL dead_gaps ovl=%0d gaps=%0d bad=%0d want 0 2 0", ovl, gaps, bad);
      end
      n_cmp++;
      if (mism != 0) begin n_fail++; $display("FAIL dead_model mism=%0d want 0", mism); end
      n_cmp++;
   endtask

   task automatic test_duty_change();
      int ah, al, ovl, gaps, bad, mism;
      measure_period(50, 9'd100, ah, al, ovl, gaps, bad, mism);
      if (ah != 240 || mism != 0) begin
         n_fail++; $display("FAIL duty_hold ah=%0d mism=%0d want 240 0", ah, mism);
      end
      n_cmp++;
      measure_period(-1, duty, ah, al, ovl, gaps, bad, mism);
      if (ah != 90 || al != 390 || bad != 0 || ovl != 0 || mism != 0) begin
         n_fail++; $display("FAIL duty_new ah=%0d al=%0d bad=%0d ovl=%0d mism=%0d want 90 390 0 0 0",
                            ah, al, bad, ovl, mism);
      end
      n_cmp++;
   endtask

   task automatic test_step_sweep();
      logic [3:0] st [3];
      logic [1:0] g [3];
      duty = 9'd250;
      for (int s = 0; s < 12; s++) begin
         st[0] = 4'(s); st[1] = 4'((s + 4) % 12); st[2] = 4'((s + 8) % 12);
         m3stepA = st[0]; m3stepB = st[1]; m3stepC = st[2];
         for (int i = 0; i < 40; i++) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
               n_fail++; $display("FAIL sweep_model s=%0d got=%b want=%b", s, dut_vec(), exp_vec());
            end
            n_cmp++;
         end
         g[0] = {gAH, gAL}; g[1] = {gBH, gBL}; g[2] = {gCH, gCL};
         for (int p = 0; p < 3; p++) begin
            if (st[p] >= 4'd8 && g[p] !== 2'b00) begin
               n_fail++; $display("FAIL sweep_float s=%0d ph=%0d got=%b want=00", s, p, g[p]);
            end
            if (st[p] >= 4'd4 && st[p] < 4'd8 && g[p] !== 2'b01) begin
               n_fail++; $display("FAIL sweep_low s=%0d ph=%0d got=%b want=01", s, p, g[p]);
            end
         end
         n_cmp++;
      end
   endtask

   task automatic test_stop();
      int first_on, guard;
      m3stepA = 4'd0; m3stepB = 4'd4; m3stepC = 4'd8; duty = 9'd250;
      guard = 0;
      while (!gAH && guard < 2 * PERIOD) begin tick(); guard++; end
      if (!gAH) begin n_fail++; $display("FAIL stop_wait_ah got=0 want=1"); end
      n_cmp++;
      m3stop = 1'b1;
      tick();
      if (dut_vec()[6:1] !== 6'b0) begin
         n_fail++; $display("FAIL stop_gates got=%b want=000000", dut_vec()[6:1]);
      end
      n_cmp++;
      for (int i = 0; i < 520; i++) begin
         tick();
         if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL stop_hold i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
         end
         n_cmp++;
      end
      m3stop = 1'b0;
      first_on = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if ((gAH || gAL) && first_on < 0) first_on = i;
      end
      if (first_on != DEAD + 1) begin
         n_fail++; $display("FAIL stop_release got=%0d want=%0d", first_on, DEAD + 1);
      end
      n_cmp++;
   endtask

   task automatic test_boundaries();
      int ah, al, ovl, gaps, bad, mism;
      bit ok;
      wait_wrap(ok);
      duty = 9'd0;
      for (int k = 0; k < 3; k++) measure_period(-1, duty, ah, al, ovl, gaps, bad, mism);
      if (ah != 0 || al != PERIOD || mism != 0) begin
         n_fail++; $display("FAIL duty_zero ah=%0d al=%0d mism=%0d want 0 500 0", ah, al, mism);
      end
      n_cmp++;
      duty = 9'd511;
      for (int k = 0; k < 3; k++) measure_period(-1, duty, ah, al, ovl, gaps, bad, mism);
      if (ah != PERIOD || al != 0 || mism != 0) begin
         n_fail++; $display("FAIL duty_clamp ah=%0d al=%0d mism=%0d want 500 0 0", ah, al, mism);
      end
      n_cmp++;
      m3stepA = 4'hE; m3stepB = 4'hE; m3stepC = 4'hE;
      tick();
      if (dut_vec()[6:1] !== 6'b0 || dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL idle_steps got=%b want=%b", dut_vec(), exp_vec());
      end
      n_cmp++;
      m3stepA = 4'd0; m3stepB = 4'd4; m3stepC = 4'd8;
      repeat (20) tick();
      pwmActive1 = 1'b0;
      tick();
      if (dut_vec()[6:1] !== 6'b0 || dut_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL inactive got=%b want=%b", dut_vec(), exp_vec());
      end
      n_cmp++;
      pwmActive1 = 1'b1;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int mism;
      m3stepA = 4'd4; m3stepB = 4'd8; m3stepC = 4'd0; duty = 9'd300;
      repeat (3) begin
         wait_wrap(ok);
         m3stepA = (m3stepA == 4'd4) ? 4'd0 : 4'd4;
         m3stepC = (m3stepC == 4'd0) ? 4'd5 : 4'd0;
         duty = 9'(duty + 9'd60);
         mism = 0;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (dut_vec() !== exp_vec()) mism++;
         end
         if (!ok || mism != 0) begin
            n_fail++; $display("FAIL wrap_step ok=%0b mism=%0d want 1 0", ok, mism);
         end
         n_cmp++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0 || (carrierWrap && $urandom_range(0, 1) == 1)) begin
            m3stepA = ($urandom_range(0, 7) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            m3stepB = 4'($urandom_range(0, 15));
            m3stepC = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 99) == 0) duty = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 199) == 0) pwmActive1 = ~pwmActive1;
         m3stop = ($urandom_range(0, 299) == 0) ? 1'b1 : (m3stop && $urandom_range(0, 3) != 0);
         tick();
         if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL random i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
         end
         n_cmp++;
         if ((gAH & gAL) | (gBH & gBL) | (gCH & gCL)) begin
            n_fail++; $display("FAIL shoot_through i=%0d got=%b want no H&L", i, dut_vec());
         end
         n_cmp++;
      end
      m3stop = 1'b0; pwmActive1 = 1'b1;
   endtask

   task automatic test_async_reset();
      m3stepA = 4'd0; m3stepB = 4'd4; m3stepC = 4'd8; duty = 9'd250;
      repeat (30) tick();
      if (!gBL) begin n_fail++; $display("FAIL arst_precond gBL=%0b want=1", gBL); end
      n_cmp++;
      nRst = 1'b0;
      #1;
      if (dut_vec() !== 7'b0) begin
         n_fail++; $display("FAIL async_reset got=%b want=%b", dut_vec(), 7'b0);
      end
      n_cmp++;
      model_reset();
      repeat (2) @(posedge clk);
      nRst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_dead_time();
      test_duty_change();
      test_step_sweep();
      test_stop();
      test_boundaries();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench timed out");
   end

endmodule
